uart_tx_arbiter: RTL and testbench

Round-robin arbiter that shares the single UART transmitter between N byte-stream requesters (CPU MMIO path, debug monitor, DMA trace, etc.). It accepts one byte at a time from the winning requester and drives the sender's `txdata`/`txen` inputs. It then tracks the sender's `txstatus` through busy and back to idle before granting again. It sits between the requesters and the UART sender, in place of the direct TXD-register write path.

---
 rtl/uart_tx_arbiter.sv | 174 +++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter that shares one UART sender between
// N_REQ byte-stream requesters. It takes one byte from the winner, pulses
// tx_en, then follows tx_status through busy and back to idle before it
// grants again.
//
// Optional feature: define UART_ARB_LOCK_EN to let the most recent owner keep
// ownership while it holds req_lock. When the macro is undefined, req_lock is
// ignored and arbitration is pure round-robin.
//
// Handshake: a requester raises req_valid[i] with req_data[8i+7:8i] and holds
// both stable until it sees the one-cycle req_ready[i] pulse. Dropping
// req_valid before a grant withdraws the request. req_data is sampled only on
// the IDLE-to-LAUNCH edge. On the sender side, tx_en is a one-cycle launch
// pulse and tx_status reads 1 when the sender is idle.
module uart_tx_arbiter #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic               CLK,
  input  logic               Reset,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_lock,
  output logic [N_REQ-1:0]   req_ready,
  input  logic               tx_status,
  output logic [7:0]         tx_data,
  output logic               tx_en,
  output logic [N_REQ-1:0]   grant,
  output logic               busy,
  output logic               timeout_err,
  input  logic               err_clr,
  output logic [1:0]         dbg_state
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LAUNCH    = 2'd1,
    S_WAIT_BUSY = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_t;

  state_t            state, state_n;
  logic [IW-1:0]     last, last_n;
  logic [TO_W-1:0]   cnt, cnt_n, cnt_inc;
  logic [7:0]        data_n;
  logic [N_REQ-1:0]  grant_n, ready_n;
  logic              en_n, err_n;

  logic              rr_found;
  logic [IW-1:0]     rr_idx;
  logic              pick_ok;
  logic [IW-1:0]     pick_idx;
  logic [7:0]        pick_byte;
  logic [N_REQ-1:0]  pick_oh;
  int                pos;

  assign cnt_inc   = cnt + TO_W'(1);
  assign dbg_state = state;

  // Round-robin search: first valid requester starting at last+1, wrapping.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = last;
    pos      = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      pos = int'(last) + k;
      if (pos >= N_REQ) pos = pos - N_REQ;
      if (!rr_found && req_valid[pos[IW-1:0]]) begin
        rr_found = 1'b1;
        rr_idx   = pos[IW-1:0];
      end
    end
  end

`ifdef UART_ARB_LOCK_EN
  // A locked previous owner is re-granted or waited for; others are held off.
  always_comb begin
    if (req_lock[last]) begin
      pick_ok  = req_valid[last];
      pick_idx = last;
    end else begin
      pick_ok  = rr_found;
      pick_idx = rr_idx;
    end
  end
`else
  logic unused_lock;
  assign unused_lock = ^req_lock;

  // Without locking the round-robin winner is always taken.
  always_comb begin
    pick_ok  = rr_found;
    pick_idx = rr_idx;
  end
`endif

  // Select the winner's byte and build its one-hot grant vector.
  always_comb begin
    pick_byte = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_idx == IW'(i)) pick_byte = req_data[8*i +: 8];
    end
    pick_oh = N_REQ'(1) << pick_idx;
  end

  // Next-state and next-output logic; outputs are registered below.
  always_comb begin
    state_n = state;
    last_n  = last;
    cnt_n   = '0;
    data_n  = tx_data;
    grant_n = grant;
    en_n    = 1'b0;
    ready_n = '0;
    err_n   = timeout_err;
    if (err_clr) err_n = 1'b0;
    case (state)
      S_IDLE: begin
        // A frame still on the line (tx_status=0) blocks any new grant.
        if (tx_status && pick_ok) begin
          state_n = S_LAUNCH;
          last_n  = pick_idx;
          data_n  = pick_byte;
          grant_n = pick_oh;
          en_n    = 1'b1;
          ready_n = pick_oh;
        end
      end
      S_LAUNCH: state_n = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (!tx_status) begin
          state_n = S_WAIT_DONE;
        end else if (cnt_inc == TO_W'(TIMEOUT)) begin
          // The sender never started: drop the byte and flag it.
          err_n   = 1'b1;
          state_n = S_IDLE;
        end else begin
          cnt_n = cnt_inc;
        end
      end
      S_WAIT_DONE: if (tx_status) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // State and registered outputs; reset also kills tx_en immediately.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state       <= S_IDLE;
      last        <= IW'(N_REQ - 1);
      cnt         <= '0;
      tx_data     <= '0;
      tx_en       <= 1'b0;
      req_ready   <= '0;
      grant       <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_n;
      last        <= last_n;
      cnt         <= cnt_n;
      tx_data     <= data_n;
      tx_en       <= en_n;
      req_ready   <= ready_n;
      grant       <= grant_n;
      busy        <= (state_n != S_IDLE);
      timeout_err <= err_n;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed sequence with a behavioural UART sender
// and an expected-launch queue checked on every tx_en pulse.
module tb_uart_tx_arbiter;

  localparam int N_REQ   = 4;
  localparam int TIMEOUT = 255;
  localparam int TO_W    = 8;
  localparam int W       = 10;  // {requester index[1:0], byte[7:0]}

  logic               CLK = 1'b0;
  logic               Reset;
  logic [N_REQ-1:0]   req_valid;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   req_lock;
  logic [N_REQ-1:0]   req_ready;
  logic               tx_status;
  logic [7:0]         tx_data;
  logic               tx_en;
  logic [N_REQ-1:0]   grant;
  logic               busy;
  logic               timeout_err;
  logic               err_clr;
  logic [1:0]         dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_e;
  logic         prev_en = 1'b0;
  logic         seen_ee = 1'b0;

  // Behavioural sender controls.
  logic snd_status = 1'b1;
  logic snd_stuck  = 1'b0;
  logic hold_low   = 1'b0;
  int   snd_cnt    = 0;
  int   frame_len  = 3;

  uart_tx_arbiter #(.N_REQ(N_REQ), .TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
    .CLK(CLK), .Reset(Reset), .req_valid(req_valid), .req_data(req_data),
    .req_lock(req_lock), .req_ready(req_ready), .tx_status(tx_status),
    .tx_data(tx_data), .tx_en(tx_en), .grant(grant), .busy(busy),
    .timeout_err(timeout_err), .err_clr(err_clr), .dbg_state(dbg_state)
  );

  // Clock and cycle counter.
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // Sender: status falls the cycle after tx_en and stays low frame_len cycles.
  always @(posedge CLK) begin
    if (tx_en && !snd_stuck) begin
      snd_status <= 1'b0;
      snd_cnt    <= frame_len - 1;
    end else if (!snd_status) begin
      if (snd_cnt == 0) snd_status <= 1'b1;
      else snd_cnt <= snd_cnt - 1;
    end
  end
  assign tx_status = snd_status & ~hold_low;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bound_fail(input string tag);
    n_tests++;
    n_fail++;
    $error("FAIL %s observed=no-event expected=event-within-budget", tag);
  endtask

  // Scoreboard: every launch must match the head of the expected queue.
  always @(negedge CLK) begin
    if (Reset) begin
      prev_en = 1'b0;
    end else begin
      if (tx_data == 8'hEE) seen_ee = 1'b1;
      if (tx_en) begin
        check("tx_en_back_to_back", {31'd0, prev_en}, 0);
        if (exp_q.size() == 0) begin
          bound_fail("unexpected_tx_en");
        end else begin
          mon_e = exp_q.pop_front();
          check("sb_tx_data", tx_data, mon_e[7:0]);
          check("sb_req_ready", req_ready, 4'b0001 << mon_e[9:8]);
          check("sb_grant", grant, 4'b0001 << mon_e[9:8]);
          check("sb_busy_launch", busy, 1);
        end
      end else begin
        check("req_ready_without_tx_en", req_ready, 0);
      end
      prev_en = tx_en;
    end
  end

  task automatic wait_ready(input int idx, input int budget);
    int n;
    n = 0;
    do begin @(negedge CLK); n++; end while (!req_ready[idx] && n < budget);
    if (!req_ready[idx]) bound_fail($sformatf("wait_ready_%0d", idx));
  endtask

  task automatic wait_any_ready(input int budget, output int w);
    int n;
    n = 0;
    w = -1;
    do begin @(negedge CLK); n++; end while (req_ready == '0 && n < budget);
    for (int i = 0; i < N_REQ; i++) if (req_ready[i]) w = i;
    if (w < 0) bound_fail("wait_any_ready");
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    do begin @(negedge CLK); n++; end while (busy && n < budget);
    if (busy) bound_fail("wait_idle");
  endtask

  task automatic apply_reset();
    Reset = 1'b1; req_valid = '0; req_lock = '0; err_clr = 1'b0; hold_low = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    Reset = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tx_data"}, tx_data, 0);
    check({tag, "_tx_en"}, tx_en, 0);
    check({tag, "_req_ready"}, req_ready, 0);
    check({tag, "_grant"}, grant, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_timeout_err"}, timeout_err, 0);
    check({tag, "_state"}, dbg_state, 0);
  endtask

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    bound_fail("global_watchdog");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w, n, t0, prev;
    logic saw_en, busy_seen;

    // Reset values.
    Reset = 1'b1; req_valid = '0; req_data = '0; req_lock = '0; err_clr = 1'b0;
    repeat (2) @(posedge CLK);
    #1 check_reset_outputs("reset");
    @(negedge CLK) Reset = 1'b0;
    @(negedge CLK) check_reset_outputs("post_release");

    // Single requester, long frame, exact launch timing.
    frame_len = 2604;
    @(posedge CLK);
    #1 req_data[7:0] = 8'h55; req_valid[0] = 1'b1; exp_q.push_back({2'd0, 8'h55});
    @(negedge CLK);
    check("t1_no_tx_en_cycle_t", tx_en, 0);
    check("t1_busy_cycle_t", busy, 0);
    @(negedge CLK);
    check("t1_tx_en_cycle_t1", tx_en, 1);
    check("t1_ready", req_ready, 4'b0001);
    check("t1_grant", grant, 4'b0001);
    req_valid[0] = 1'b0;
    @(negedge CLK);
    check("t1_status_fall", tx_status, 0);
    check("t1_state_wait_busy", dbg_state, 2);
    n = 0;
    while (!tx_status && n < 3000) begin @(negedge CLK); n++; end
    if (!tx_status) bound_fail("t1_status_rise");
    check("t1_busy_at_rise", busy, 1);
    @(negedge CLK);
    check("t1_busy_after_rise", busy, 0);
    check("t1_tx_data_hold", tx_data, 8'h55);
    check("t1_grant_hold", grant, 4'b0001);
    check("t1_queue_empty", exp_q.size(), 0);

    // All four valid: round-robin order 0,1,2,3,0,1 at a fixed spacing.
    apply_reset();
    frame_len = 3;
    req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    exp_q.push_back({2'd0, 8'hA0}); exp_q.push_back({2'd1, 8'hA1});
    exp_q.push_back({2'd2, 8'hA2}); exp_q.push_back({2'd3, 8'hA3});
    exp_q.push_back({2'd0, 8'hA0}); exp_q.push_back({2'd1, 8'hA1});
    req_valid = 4'hF;
    prev = 0;
    for (int g = 0; g < 6; g++) begin
      wait_any_ready(400, w);
      if (w < 0) break;
      if (g > 0) check("rr_launch_spacing", cyc - prev, 6);
      prev = cyc;
    end
    req_valid = '0;
    wait_idle(100);
    check("rr_queue_empty", exp_q.size(), 0);

    // Stuck sender: timeout, fresh grant, set-beats-clear, then clear.
    snd_stuck = 1'b1;
    req_data[7:0] = 8'h60; req_data[23:16] = 8'h62;
    exp_q.push_back({2'd2, 8'h62}); exp_q.push_back({2'd0, 8'h60});
    req_valid = 4'b0101;
    wait_ready(2, 50);
    t0 = cyc;
    req_valid[2] = 1'b0;
    n = 0;
    while (!timeout_err && n < 400) begin @(negedge CLK); n++; end
    if (!timeout_err) bound_fail("to_err_set");
    check("to_err_delay", cyc - t0, TIMEOUT + 1);
    check("to_back_in_idle", busy, 0);
    err_clr = 1'b1;
    wait_ready(0, 10);
    check("to_err_cleared", timeout_err, 0);
    t0 = cyc;
    req_valid[0] = 1'b0;
    wait_idle(400);
    check("to_err_set_wins_over_clr", timeout_err, 1);
    check("to_err_delay2", cyc - t0, TIMEOUT + 1);
    err_clr = 1'b0;
    @(negedge CLK);
    check("to_err_sticky", timeout_err, 1);
    @(posedge CLK); #1 err_clr = 1'b1;
    @(posedge CLK); #1 err_clr = 1'b0;
    @(negedge CLK);
    check("to_err_clr", timeout_err, 0);
    snd_stuck = 1'b0;
    check("to_queue_empty", exp_q.size(), 0);

    // Reset in WAIT_DONE with grant=0100, then wait for the line to free.
    frame_len = 50;
    req_data[23:16] = 8'h24;
    exp_q.push_back({2'd2, 8'h24});
    req_valid = 4'b0100;
    wait_ready(2, 50);
    req_valid = '0;
    n = 0;
    while (dbg_state != 2'd3 && n < 10) begin @(negedge CLK); n++; end
    if (dbg_state != 2'd3) bound_fail("rst_reach_wait_done");
    check("rst_grant_before", grant, 4'b0100);
    @(posedge CLK);
    #2 Reset = 1'b1;
    #1 check_reset_outputs("midframe_reset");
    repeat (2) @(posedge CLK);
    @(negedge CLK) Reset = 1'b0;
    req_data[7:0] = 8'h30; req_data[23:16] = 8'h32;
    exp_q.push_back({2'd0, 8'h30});
    req_valid = 4'b0101;
    saw_en = 1'b0; n = 0;
    while (!tx_status && n < 100) begin
      @(negedge CLK);
      saw_en = saw_en | tx_en;
      n++;
    end
    check("rst_no_launch_while_line_busy", saw_en, 0);
    wait_ready(0, 10);
    req_valid = '0;
    wait_idle(100);
    check("rst_req0_wins_data", tx_data, 8'h30);
    check("rst_req0_wins_grant", grant, 4'b0001);
    check("rst_queue_empty", exp_q.size(), 0);

    // req1 locked with 3 bytes while req0 and req2 stay valid.
    frame_len = 3;
    req_data[7:0] = 8'h70; req_data[15:8] = 8'h11; req_data[23:16] = 8'h72;
`ifdef UART_ARB_LOCK_EN
    exp_q.push_back({2'd1, 8'h11}); exp_q.push_back({2'd1, 8'h12});
    exp_q.push_back({2'd1, 8'h13}); exp_q.push_back({2'd2, 8'h72});
    exp_q.push_back({2'd0, 8'h70});
`else
    exp_q.push_back({2'd1, 8'h11}); exp_q.push_back({2'd2, 8'h72});
    exp_q.push_back({2'd0, 8'h70}); exp_q.push_back({2'd1, 8'h12});
    exp_q.push_back({2'd1, 8'h13});
`endif
    req_lock[1] = 1'b1;
    req_valid = 4'b0111;
    n = 0;
    for (int g = 0; g < 5; g++) begin
      wait_any_ready(200, w);
      if (w < 0) break;
      if (w == 1) begin
        n++;
        if (n == 3) begin req_valid[1] = 1'b0; req_lock[1] = 1'b0; end
        else req_data[15:8] = 8'(8'h11 + n);
      end else if (w == 0) req_valid[0] = 1'b0;
      else if (w == 2) req_valid[2] = 1'b0;
    end
    wait_idle(100);
    check("lock_queue_empty", exp_q.size(), 0);

    // req3 withdrawn in the cycle req0 is selected.
    apply_reset();
    req_data[23:16] = 8'h42;
    exp_q.push_back({2'd2, 8'h42});
    req_valid = 4'b0100;
    wait_ready(2, 20);
    req_valid = '0;
    wait_idle(100);
    seen_ee = 1'b0;
    hold_low = 1'b1;
    req_data[31:24] = 8'hEE; req_data[7:0] = 8'h0F;
    exp_q.push_back({2'd0, 8'h0F});
    req_valid = 4'b1001;
    saw_en = 1'b0; busy_seen = 1'b0;
    repeat (5) begin
      @(negedge CLK);
      saw_en = saw_en | tx_en;
      busy_seen = busy_seen | busy;
    end
    check("wd_no_launch_foreign_frame", saw_en, 0);
    check("wd_idle_foreign_frame", busy_seen, 0);
    @(posedge CLK);
    #1 hold_low = 1'b0; req_valid[3] = 1'b0;
    wait_ready(0, 10);
    req_valid = '0;
    wait_idle(100);
    check("wd_req3_byte_never_sent", seen_ee, 0);
    check("wd_tx_data", tx_data, 8'h0F);
    check("wd_grant", grant, 4'b0001);
    check("wd_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
